// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state, opcode/funct, cause and datapath-select encodings
// shared by the multi-cycle control FSM and its memory-wait helper.
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        S_IF    = 5'd0,
        S_ID    = 5'd1,
        S_ADDR  = 5'd2,
        S_MRD   = 5'd3,
        S_WB    = 5'd4,
        S_MWR   = 5'd5,
        S_EXEC  = 5'd6,
        S_RCOMP = 5'd7,
        S_J     = 5'd9,
        S_IMM   = 5'd10,
        S_IMMU  = 5'd11,
        S_ICOMP = 5'd12,
        S_BEQ   = 5'd13,
        S_BNE   = 5'd14,
        S_LUI   = 5'd15,
        S_JAL   = 5'd16,
        S_JR    = 5'd17,
        S_JALR  = 5'd18,
        S_TRAP  = 5'd19,
        S_RST   = 5'd31
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_ILL  = 2'b01;
    localparam logic [1:0] CAUSE_BUS  = 2'b10;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_REG  = 2'b01;
    localparam logic [1:0] PCSRC_JMP  = 2'b10;
    localparam logic [1:0] PCSRC_TRAP = 2'b11;

    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] RD_R31 = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_4     = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_IMM   = 2'b11;

    // R-type functs that complete through RCOMP
    function automatic logic is_rfunct(input logic [5:0] fn);
        case (fn)
            FN_SLL, FN_SRL, FN_SRA,
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_XOR, FN_NOR,
            FN_SLT, FN_SLTU: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_mem_wait.sv
// mc_mem_wait: counts wait cycles of a pending memory access and flags
// a bus error when MEM_TIMEOUT cycles pass without mem_ready.
module mc_mem_wait #(
    parameter int TMO_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic i_active,
    input  logic i_ready,
    output logic o_bus_err
);

    logic [TMO_W-1:0] r_cnt;
    logic             w_wait;

    assign w_wait    = i_active && !i_ready;
    assign o_bus_err = w_wait && (r_cnt == TMO_W'(MEM_TIMEOUT - 1));

    // any cycle that is not a continuing wait leaves the count at zero,
    // so every fresh access starts from a clean counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (w_wait && !o_bus_err)
            r_cnt <= r_cnt + TMO_W'(1);
        else
            r_cnt <= '0;
    end

endmodule

// File: rtl/mc_control_hs.sv
// mc_control_hs: multi-cycle main control FSM with memory handshake,
// wait timeout and trap state. Optional counters: MC_PERF_CNT_EN.
module mc_control_hs
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 2,
    parameter int TMO_W       = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IorD,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               BranchNotEqual,
    output logic [1:0]         PCSrc,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               ZeroExt,
    output logic               EPCWrite,
    output logic               CauseWrite,
    output logic [1:0]         cause,
    output logic [4:0]         state
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   instret_cnt
`endif
);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_cause;
    logic [1:0] w_cause;
    logic [1:0] w_aluop;
    logic       w_mem_active;
    logic       w_bus_err;

    assign state        = r_state;
    assign ALUOp        = ALUOP_W'(w_aluop);
    assign w_mem_active = r_state inside {S_IF, S_MRD, S_MWR};

    mc_mem_wait #(
        .TMO_W       (TMO_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait (
        .clk       (clk),
        .reset     (reset),
        .i_active  (w_mem_active),
        .i_ready   (mem_ready),
        .o_bus_err (w_bus_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RST;
            r_cause <= CAUSE_NONE;
        end else begin
            r_state <= w_next;
            r_cause <= w_cause;
        end
    end

    always_comb begin
        w_next         = S_IF;
        w_cause        = r_cause;
        mem_req        = 1'b0;
        MemRead        = 1'b0;
        MemWrite       = 1'b0;
        IorD           = 1'b0;
        IRWrite        = 1'b0;
        PCWrite        = 1'b0;
        PCWriteCond    = 1'b0;
        BranchNotEqual = 1'b0;
        PCSrc          = PCSRC_ALU;
        RegDst         = RD_RT;
        MemtoReg       = M2R_ALU;
        RegWrite       = 1'b0;
        ALUSrcA        = 1'b0;
        ALUSrcB        = SRCB_RT;
        w_aluop        = ALU_ADD;
        ZeroExt        = 1'b0;
        EPCWrite       = 1'b0;
        CauseWrite     = 1'b0;
        cause          = CAUSE_NONE;
        case (r_state)
            S_RST: w_next = S_IF;
            S_IF: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                ALUSrcB = SRCB_4;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) begin
                    w_next = S_ID;
                end else if (w_bus_err) begin
                    w_next  = S_TRAP;
                    w_cause = CAUSE_BUS;
                end else begin
                    w_next = S_IF;
                end
            end
            S_ID: begin
                ALUSrcB = SRCB_IMMSH;
                case (opcode)
                    OP_RTYPE:                   w_next = S_EXEC;
                    OP_LW, OP_SW:               w_next = S_ADDR;
                    OP_ADDI, OP_SLTI:           w_next = S_IMM;
                    OP_ANDI, OP_ORI, OP_XORI:   w_next = S_IMMU;
                    OP_LUI:                     w_next = S_LUI;
                    OP_J:                       w_next = S_J;
                    OP_JAL:                     w_next = S_JAL;
                    OP_BEQ:                     w_next = S_BEQ;
                    OP_BNE:                     w_next = S_BNE;
                    default: begin
                        w_next  = S_TRAP;
                        w_cause = CAUSE_ILL;
                    end
                endcase
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                w_aluop = ALU_FUNCT;
                if (funct == FN_JR) begin
                    w_next = S_JR;
                end else if (funct == FN_JALR) begin
                    w_next = S_JALR;
                end else if (is_rfunct(funct)) begin
                    w_next = S_RCOMP;
                end else begin
                    w_next  = S_TRAP;
                    w_cause = CAUSE_ILL;
                end
            end
            S_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                w_next  = (opcode == OP_LW) ? S_MRD : S_MWR;
            end
            S_MRD, S_MWR: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemRead  = (r_state == S_MRD);
                MemWrite = (r_state == S_MWR);
                if (mem_ready) begin
                    w_next = (r_state == S_MRD) ? S_WB : S_IF;
                end else if (w_bus_err) begin
                    w_next  = S_TRAP;
                    w_cause = CAUSE_BUS;
                end else begin
                    w_next = r_state;
                end
            end
            S_IMM, S_IMMU, S_LUI: begin
                ALUSrcA = (r_state != S_LUI);
                ALUSrcB = SRCB_IMM;
                w_aluop = ALU_IMM;
                ZeroExt = (r_state == S_IMMU);
                w_next  = S_ICOMP;
            end
            S_RCOMP: begin
                RegDst   = RD_RD;
                RegWrite = 1'b1;
            end
            S_ICOMP: RegWrite = 1'b1;
            S_WB: begin
                MemtoReg = M2R_MDR;
                RegWrite = 1'b1;
            end
            S_BEQ, S_BNE: begin
                ALUSrcA        = 1'b1;
                w_aluop        = ALU_SUB;
                PCWriteCond    = 1'b1;
                PCSrc          = PCSRC_REG;
                BranchNotEqual = (r_state == S_BNE);
            end
            S_J, S_JAL: begin
                PCWrite = 1'b1;
                PCSrc   = PCSRC_JMP;
                if (r_state == S_JAL) begin
                    RegDst   = RD_R31;
                    MemtoReg = M2R_PC;
                    RegWrite = 1'b1;
                end
            end
            S_JR, S_JALR: begin
                PCWrite = 1'b1;
                PCSrc   = PCSRC_REG;
                if (r_state == S_JALR) begin
                    RegDst   = RD_R31;
                    MemtoReg = M2R_PC;
                    RegWrite = 1'b1;
                end
            end
            S_TRAP: begin
                EPCWrite   = 1'b1;
                CauseWrite = 1'b1;
                PCWrite    = 1'b1;
                PCSrc      = PCSRC_TRAP;
                cause      = r_cause;
            end
            default: w_next = S_IF;
        endcase
        // a new instruction starts with no pending cause
        if (w_next == S_IF)
            w_cause = CAUSE_NONE;
    end

`ifdef MC_PERF_CNT_EN
    logic w_retire;

    always_comb begin
        case (r_state)
            S_RCOMP, S_ICOMP, S_WB, S_BEQ, S_BNE,
            S_J, S_JAL, S_JR, S_JALR: w_retire = 1'b1;
            S_MWR:                    w_retire = mem_ready;
            default:                  w_retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (r_state != S_RST)
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (w_retire)
                instret_cnt <= instret_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
